// File: rtl/alu_entry_pkg.sv
// Shared types and widths for the ALU operand entry block.
package alu_entry_pkg;
  localparam int OPERAND_W = 4;
  localparam int OPCODE_W  = 3;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } entry_state_t;
endpackage

// File: rtl/button_conditioner.sv
// Synchronizes, optionally debounces (ALU_ENTRY_DEBOUNCE_EN) and edge-detects one raw pushbutton.
// Press pulse lands SYNC_STAGES+DEBOUNCE_CYCLES edges after first sample (SYNC_STAGES+1 without debounce).
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] sync_q;
  logic              sync_lvl;
  logic              level_q;
  logic              level_prev_q;
  logic              press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], btn_i};
    end
  end

  assign sync_lvl = sync_q[SYNC_N-1];

`ifdef ALU_ENTRY_DEBOUNCE_EN
  localparam int unsigned DEB_N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W = (DEB_N < 2) ? 1 : $clog2(DEB_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;

  // Any cycle where the synchronized level agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_lvl != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= sync_lvl;
    end
  end

  // DEBOUNCE_CYCLES has no effect in this build.
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_ignored
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/alu_operand_entry.sv
// Steps the user through entering A, B and opcode from switches; debounce enabled by ALU_ENTRY_DEBOUNCE_EN.
// Outputs update one edge after a conditioned press; clear overrides enter.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           switches,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic [OPCODE_W-1:0]  select,
  output logic                 operands_valid,
  output logic                 load_strobe,
  output logic [1:0]           stage
);
  logic enter_pulse;
  logic clear_pulse;

  entry_state_t         state_q;
  logic [OPERAND_W-1:0] a_q;
  logic [OPERAND_W-1:0] b_q;
  logic [OPCODE_W-1:0]  sel_q;
  logic                 valid_q;
  logic                 strobe_q;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_enter),
    .press_o (enter_pulse)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_clear),
    .press_o (clear_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (clear_pulse) begin
        state_q <= LOAD_A;
        a_q     <= '0;
        b_q     <= '0;
        sel_q   <= '0;
        valid_q <= 1'b0;
      end else if (enter_pulse) begin
        case (state_q)
          LOAD_A: begin
            a_q     <= switches;
            state_q <= LOAD_B;
          end
          LOAD_B: begin
            b_q     <= switches;
            state_q <= LOAD_OP;
          end
          LOAD_OP: begin
            sel_q    <= switches[OPCODE_W-1:0];
            state_q  <= SHOW;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
          end
          default: begin
            // Operands stay visible after leaving SHOW until recaptured.
            state_q <= LOAD_A;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign select         = sel_q;
  assign operands_valid = valid_q;
  assign load_strobe    = strobe_q;
  assign stage          = state_q;
endmodule

// File: doc/alu_operand_entry.md
ALU_OPERAND_ENTRY -- requirements
Module: alu_operand_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flops in each button synchronizer (minimum 2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- switches  input  4  operand/opcode nibble from the board switches.
- btn_enter  input  1  raw enter pushbutton, active-high, asynchronous to clk.
- btn_clear  input  1  raw clear pushbutton, active-high, asynchronous to clk.
- A  output  4  captured operand A, to the ALU.
- B  output  4  captured operand B, to the ALU.
- select  output  3  captured ALU opcode.
- operands_valid  output  1  high while A, B and select form a complete set.
- load_strobe  output  1  one-cycle pulse when operands_valid rises.
- stage  output  2  current entry state, for status LEDs.

Function
REQ-004 SHALL pass each button through SYNC_STAGES flip-flops before any other logic.
REQ-005 SHALL update a button's debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; a glitch shorter than that SHALL restart the count.
REQ-006 SHALL produce a one-cycle press pulse on each 0->1 debounced transition; releases produce nothing.
REQ-007 Latency: an enter press held high SHALL pulse exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first rising clk edge that samples it high.
REQ-008 SHALL implement the states LOAD_A=0, LOAD_B=1, LOAD_OP=2 and SHOW=3, visible on stage.
REQ-009 LOAD_A + enter pulse: A <= switches, next state LOAD_B.
REQ-010 LOAD_B + enter pulse: B <= switches, next state LOAD_OP.
REQ-011 LOAD_OP + enter pulse: select <= switches[2:0], with switches[3] ignored; next state SHOW.
REQ-012 On entering SHOW, operands_valid SHALL go high and load_strobe SHALL pulse for that one cycle.
REQ-013 SHOW + enter pulse: next state LOAD_A and operands_valid low; A, B and select SHALL hold their values until overwritten.
REQ-014 A clear pulse in any state SHALL force LOAD_A and set A, B, select and operands_valid to 0.
REQ-015 When clear and enter pulse in the same cycle, clear SHALL win.
REQ-016 Switch changes without an enter pulse SHALL never alter the outputs.

Reset
REQ-017 rst_n low SHALL immediately set: state LOAD_A, A/B/select 0, operands_valid 0, load_strobe 0, all synchronizer, debounce and counter state 0.
REQ-018 Reset asserted mid-debounce or mid-entry SHALL discard the partial press and the partial operand set.

Configuration
REQ-019 Macro ALU_ENTRY_DEBOUNCE_EN, when defined, SHALL enable the debounce counters as specified in REQ-005.
REQ-020 Without ALU_ENTRY_DEBOUNCE_EN, the press pulse SHALL be edge-detected directly from the synchronizer output (latency SYNC_STAGES+1), and DEBOUNCE_CYCLES SHALL be ignored.

Structure
REQ-021 Package alu_entry_pkg SHALL hold the entry_state_t enum (2 bits), OPERAND_W=4 and OPCODE_W=3.
REQ-022 Sub-module button_conditioner SHALL implement sync, debounce and rising-edge pulse; it SHALL be instantiated once per button.

Verification (bench: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, macro defined)
REQ-023 Full entry sequence:
- switches=0x5, enter; then switches=0xA, enter; then switches=0xB, enter.
- Required: A=5, B=0xA, select=3, stage=3, operands_valid=1, one load_strobe pulse.
REQ-024 Glitch rejection:
- enter high for 3 cycles, then low.
- Required: no pulse, stage stays 0, A stays 0.
REQ-025 Latency: enter held high; the pulse SHALL occur exactly 6 cycles after the first sampling edge, and only once while held.
REQ-026 Simultaneous clear and enter:
- Precondition: stage=2, A=5, B=0xA.
- Required: stage=0 and A=B=select=0.
REQ-027 Reset mid-entry:
- Precondition: stage=1, A=5.
- rst_n pulsed low between clock edges.
- Required: outputs 0 asynchronously; a subsequent entry works normally.
REQ-028 Wrap from SHOW:
- From SHOW with A=5, press enter.
- Required: stage=0, operands_valid=0, A stays 5 until the next capture.
